sumador_serial: RTL and testbench



---
 rtl/sumador_serial.sv | 140 ++++++++++++++
 tb/tb_sumador_serial.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sumador_serial.sv
// Bit-serial N-bit adder: latches A/B/Cin on inicio, adds LSB first over N cycles,
// then presents registered S/Cout with a one-cycle valido. Optional SUMADOR_SERIAL_OVF_EN adds ovf.
module sumador_serial #(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inicio,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Cin,
   output logic         listo,
   output logic         valido,
   output logic [N-1:0] S,
   output logic         Cout
`ifdef SUMADOR_SERIAL_OVF_EN
   ,
   output logic         ovf
`endif
);

   localparam int unsigned CW = $clog2(N);

   typedef enum logic [1:0] {
      REPOSO  = 2'd0,
      SUMANDO = 2'd1,
      FIN     = 2'd2
   } estado_t;

   estado_t        r_estado;
   estado_t        w_estado_nxt;
   logic           w_carga;
   logic           w_paso;
   logic           w_ultimo;

   logic [N-1:0]   r_ra;
   logic [N-1:0]   r_rb;
   logic [N-1:0]   r_rs;
   logic           r_c;
   logic [CW-1:0]  r_cnt;
   logic           r_listo;
   logic           r_valido;
   logic [N-1:0]   r_s;
   logic           r_cout;

   logic           w_s;
   logic           w_c_nxt;
   logic [N-1:0]   w_rs_nxt;

   // One full-adder cell worth of logic, fed from the bit-0 positions.
   assign w_s      = r_ra[0] ^ r_rb[0] ^ r_c;
   assign w_c_nxt  = (r_ra[0] & r_rb[0]) | ((r_ra[0] ^ r_rb[0]) & r_c);
   assign w_rs_nxt = {w_s, r_rs[N-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_estado <= REPOSO;
      else     r_estado <= w_estado_nxt;
   end

   always_comb begin
      w_estado_nxt = r_estado;
      w_carga      = 1'b0;
      w_paso       = 1'b0;
      w_ultimo     = 1'b0;
      unique case (r_estado)
         REPOSO: begin
            if (inicio) begin
               w_carga      = 1'b1;
               w_estado_nxt = SUMANDO;
            end
         end
         SUMANDO: begin
            w_paso = 1'b1;
            if (r_cnt == CW'(N - 1)) begin
               w_ultimo     = 1'b1;
               w_estado_nxt = FIN;
            end
         end
         FIN:     w_estado_nxt = REPOSO;
         default: w_estado_nxt = REPOSO;
      endcase
   end

   // Status flags registered from the next state so they line up with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_listo  <= 1'b1;
         r_valido <= 1'b0;
      end else begin
         r_listo  <= (w_estado_nxt == REPOSO);
         r_valido <= (w_estado_nxt == FIN);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ra   <= '0;
         r_rb   <= '0;
         r_rs   <= '0;
         r_c    <= 1'b0;
         r_cnt  <= '0;
         r_s    <= '0;
         r_cout <= 1'b0;
      end else if (w_carga) begin
         r_ra  <= A;
         r_rb  <= B;
         r_c   <= Cin;
         r_cnt <= '0;
      end else if (w_paso) begin
         r_c  <= w_c_nxt;
         r_ra <= {1'b0, r_ra[N-1:1]};
         r_rb <= {1'b0, r_rb[N-1:1]};
         r_rs <= w_rs_nxt;
         if (w_ultimo) begin
            r_s    <= w_rs_nxt;
            r_cout <= w_c_nxt;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

`ifdef SUMADOR_SERIAL_OVF_EN
   logic r_ovf;

   // During the last step r_c holds the carry into the MSB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           r_ovf <= 1'b0;
      else if (w_ultimo) r_ovf <= r_c ^ w_c_nxt;
   end

   assign ovf = r_ovf;
`endif

   assign listo  = r_listo;
   assign valido = r_valido;
   assign S      = r_s;
   assign Cout   = r_cout;

endmodule

// File: tb/tb_sumador_serial.sv
// Directed bench for sumador_serial: N=8 instance for function/timing/reset, N=4 for back-to-back.
module tb_sumador_serial;

   logic       clk = 1'b0;
   logic       rst;
   logic       inicio;
   logic [7:0] a8, b8;
   logic       cin8;
   logic       listo, valido;
   logic [7:0] s8;
   logic       cout8;

   logic       inicio4;
   logic [3:0] a4, b4;
   logic       cin4;
   logic       listo4, valido4;
   logic [3:0] s4;
   logic       cout4;

`ifdef SUMADOR_SERIAL_OVF_EN
   logic       ovf8, ovf4;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sumador_serial #(.N(8)) u_dut8 (
      .clk(clk), .rst(rst), .inicio(inicio), .A(a8), .B(b8), .Cin(cin8),
      .listo(listo), .valido(valido), .S(s8), .Cout(cout8)
`ifdef SUMADOR_SERIAL_OVF_EN
      , .ovf(ovf8)
`endif
   );

   sumador_serial #(.N(4)) u_dut4 (
      .clk(clk), .rst(rst), .inicio(inicio4), .A(a4), .B(b4), .Cin(cin4),
      .listo(listo4), .valido(valido4), .S(s4), .Cout(cout4)
`ifdef SUMADOR_SERIAL_OVF_EN
      , .ovf(ovf4)
`endif
   );

   // Starts one N=8 addition and returns the cycle (after the accept edge) where valido appears.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, output int vcyc);
      vcyc = -1;
      for (int w = 0; w < 20 && !listo; w++) begin
         @(posedge clk); #1;
      end
      a8 = a; b8 = b; cin8 = c; inicio = 1'b1;
      @(posedge clk); #1;
      inicio = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~c;
      for (int j = 1; j <= 20; j++) begin
         @(posedge clk); #1;
         if (valido) begin
            vcyc = j;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; inicio = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      inicio4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
      #12;
      n_chk++; if (listo !== 1'b1) begin n_fail++; $display("FAIL reset_listo: got %b expected 1", listo); end
      n_chk++; if (valido !== 1'b0) begin n_fail++; $display("FAIL reset_valido: got %b expected 0", valido); end
      n_chk++; if (s8 !== 8'h00) begin n_fail++; $display("FAIL reset_S: got %h expected 00", s8); end
      n_chk++; if (cout8 !== 1'b0) begin n_fail++; $display("FAIL reset_Cout: got %b expected 0", cout8); end
`ifdef SUMADOR_SERIAL_OVF_EN
      n_chk++; if (ovf8 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf8); end
`endif
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int v;
      op8(8'h5A, 8'h3C, 1'b0, v);
      n_chk++; if (v !== 8) begin n_fail++; $display("FAIL basic_latency: got %0d expected 8", v); end
      n_chk++; if (s8 !== 8'h96) begin n_fail++; $display("FAIL basic_S: got %h expected 96", s8); end
      n_chk++; if (cout8 !== 1'b0) begin n_fail++; $display("FAIL basic_Cout: got %b expected 0", cout8); end
      n_chk++; if (listo !== 1'b0) begin n_fail++; $display("FAIL basic_listo_fin: got %b expected 0", listo); end
      @(posedge clk); #1;
      n_chk++; if (valido !== 1'b0) begin n_fail++; $display("FAIL basic_valido_pulse: got %b expected 0", valido); end
      n_chk++; if (listo !== 1'b1) begin n_fail++; $display("FAIL basic_listo_back: got %b expected 1", listo); end
   endtask

   task automatic test_carry();
      int v;
      op8(8'hFF, 8'h01, 1'b0, v);
      n_chk++; if (v !== 8) begin n_fail++; $display("FAIL carry1_latency: got %0d expected 8", v); end
      n_chk++; if (s8 !== 8'h00) begin n_fail++; $display("FAIL carry1_S: got %h expected 00", s8); end
      n_chk++; if (cout8 !== 1'b1) begin n_fail++; $display("FAIL carry1_Cout: got %b expected 1", cout8); end
      op8(8'hFF, 8'hFF, 1'b1, v);
      n_chk++; if (s8 !== 8'hFF) begin n_fail++; $display("FAIL carry2_S: got %h expected ff", s8); end
      n_chk++; if (cout8 !== 1'b1) begin n_fail++; $display("FAIL carry2_Cout: got %b expected 1", cout8); end
   endtask

   task automatic test_ignore();
      int vj;
      int bad;
      for (int w = 0; w < 20 && !listo; w++) begin
         @(posedge clk); #1;
      end
      a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; inicio = 1'b1;
      @(posedge clk); #1;
      vj = -1; bad = 0;
      for (int j = 1; j <= 12; j++) begin
         a8 = 8'(j * 37); b8 = 8'(j * 91); cin8 = j[0];
         @(posedge clk); #1;
         if (valido) begin
            vj = j;
            break;
         end
         if (s8 !== 8'hFF) bad++;
      end
      inicio = 1'b0;
      n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL ignore_S_hold: got %0d early changes expected 0", bad); end
      n_chk++; if (vj !== 8) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 8", vj); end
      n_chk++; if (s8 !== 8'h33) begin n_fail++; $display("FAIL ignore_S: got %h expected 33", s8); end
      n_chk++; if (cout8 !== 1'b0) begin n_fail++; $display("FAIL ignore_Cout: got %b expected 0", cout8); end
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_chk++; if (listo !== 1'b1) begin n_fail++; $display("FAIL ignore_idle: got %b expected 1", listo); end
      n_chk++; if (s8 !== 8'h33) begin n_fail++; $display("FAIL ignore_S_after: got %h expected 33", s8); end
   endtask

   task automatic test_reset_mid();
      int seen;
      int v;
      a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; inicio = 1'b1;
      @(posedge clk); #1;
      inicio = 1'b0;
      repeat (4) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      n_chk++; if (listo !== 1'b1) begin n_fail++; $display("FAIL rstmid_listo: got %b expected 1", listo); end
      n_chk++; if (valido !== 1'b0) begin n_fail++; $display("FAIL rstmid_valido: got %b expected 0", valido); end
      n_chk++; if (s8 !== 8'h00) begin n_fail++; $display("FAIL rstmid_S: got %h expected 00", s8); end
      n_chk++; if (cout8 !== 1'b0) begin n_fail++; $display("FAIL rstmid_Cout: got %b expected 0", cout8); end
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      for (int j = 0; j < 15; j++) begin
         @(posedge clk); #1;
         if (valido) seen++;
      end
      n_chk++; if (seen !== 0) begin n_fail++; $display("FAIL rstmid_no_valido: got %0d pulses expected 0", seen); end
      op8(8'h12, 8'h34, 1'b0, v);
      n_chk++; if (s8 !== 8'h46) begin n_fail++; $display("FAIL rstmid_fresh_S: got %h expected 46", s8); end
      n_chk++; if (cout8 !== 1'b0) begin n_fail++; $display("FAIL rstmid_fresh_Cout: got %b expected 0", cout8); end
   endtask

`ifdef SUMADOR_SERIAL_OVF_EN
   task automatic test_ovf();
      int v;
      op8(8'h7F, 8'h01, 1'b0, v);
      n_chk++; if ({s8, cout8, ovf8} !== {8'h80, 1'b0, 1'b1}) begin n_fail++; $display("FAIL ovf_7f01: got S=%h C=%b V=%b expected S=80 C=0 V=1", s8, cout8, ovf8); end
      op8(8'h80, 8'h80, 1'b0, v);
      n_chk++; if ({s8, cout8, ovf8} !== {8'h00, 1'b1, 1'b1}) begin n_fail++; $display("FAIL ovf_8080: got S=%h C=%b V=%b expected S=00 C=1 V=1", s8, cout8, ovf8); end
      op8(8'hFF, 8'h01, 1'b0, v);
      n_chk++; if ({s8, cout8, ovf8} !== {8'h00, 1'b1, 1'b0}) begin n_fail++; $display("FAIL ovf_ff01: got S=%h C=%b V=%b expected S=00 C=1 V=0", s8, cout8, ovf8); end
   endtask
`endif

   task automatic test_back_to_back();
      logic [3:0] ea [3];
      logic [3:0] eb [3];
      logic       ec [3];
      logic [3:0] es [3];
      logic       eco [3];
      int         idx;
      logic       exp_v;
      ea = '{4'h3, 4'hF, 4'h9};  eb = '{4'h5, 4'h1, 4'hA};  ec = '{1'b0, 1'b0, 1'b1};
      es = '{4'h8, 4'h0, 4'h4};  eco = '{1'b0, 1'b1, 1'b1};
      idx = 0;
      a4 = ea[0]; b4 = eb[0]; cin4 = ec[0]; inicio4 = 1'b1;
      @(posedge clk); #1;
      a4 = ea[1]; b4 = eb[1]; cin4 = ec[1];
      for (int t = 1; t <= 20; t++) begin
         @(posedge clk); #1;
         if (t == 6) begin a4 = ea[2]; b4 = eb[2]; cin4 = ec[2]; end
         if (t == 12) inicio4 = 1'b0;
         exp_v = (t == 4) || (t == 10) || (t == 16);
         n_chk++;
         if (valido4 !== exp_v) begin n_fail++; $display("FAIL b2b_valido_t%0d: got %b expected %b", t, valido4, exp_v); end
         if (valido4 && idx < 3) begin
            n_chk++;
            if ({s4, cout4} !== {es[idx], eco[idx]}) begin
               n_fail++;
               $display("FAIL b2b_result%0d: got S=%h C=%b expected S=%h C=%b", idx, s4, cout4, es[idx], eco[idx]);
            end
            idx++;
         end
      end
      n_chk++; if (idx !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", idx); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry();
      test_ignore();
      test_reset_mid();
`ifdef SUMADOR_SERIAL_OVF_EN
      test_ovf();
`endif
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
